id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 40 ++++
 rtl/id_ex_stage_hazard_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 119 +++++++++++
 tb/tb_id_ex_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control bundle and bubble helper for the ID/EX pipeline stage.
package id_ex_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 2;

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
    } opnd_t;

    localparam ctrl_t CTRL_ZERO = '0;

    // Squash the side-effecting controls; ALU steering fields pass through as don't-care.
    function automatic ctrl_t bubble_ctrl(input ctrl_t c);
        ctrl_t b;
        b            = c;
        b.reg_write  = CTRL_ZERO.reg_write;
        b.mem_to_reg = CTRL_ZERO.mem_to_reg;
        b.mem_read   = CTRL_ZERO.mem_read;
        b.mem_write  = CTRL_ZERO.mem_write;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: EX holds a load whose destination is read by the ID instruction.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic                  i_stall,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rt_addr,
    output logic                  o_hazard_c
);

    logic w_addr_match;
    logic w_nonzero;

    assign w_nonzero    = (i_ex_rt_addr != REG_ADDR_W'(0));
    assign w_addr_match = (i_ex_rt_addr == i_id_rs_addr) | (i_ex_rt_addr == i_id_rt_addr);
    assign o_hazard_c   = !i_stall & i_ex_valid & i_ex_mem_read & w_nonzero & w_addr_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion (flush / load-use) and saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned BCNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [DATA_W-1:0]     rsData_i,
    input  logic [DATA_W-1:0]     rtData_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rsAddr_i,
    input  logic [REG_ADDR_W-1:0] rtAddr_i,
    input  logic [REG_ADDR_W-1:0] rdAddr_i,
    input  logic                  regWrite_i,
    input  logic                  memToReg_i,
    input  logic                  memRead_i,
    input  logic                  memWrite_i,
    input  logic                  aluSrc_i,
    input  logic                  regDst_i,
    input  logic [ALUOP_W-1:0]    aluOp_i,
    output logic [DATA_W-1:0]     rsData_o,
    output logic [DATA_W-1:0]     rtData_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] rsAddr_o,
    output logic [REG_ADDR_W-1:0] rtAddr_o,
    output logic [REG_ADDR_W-1:0] rdAddr_o,
    output logic                  regWrite_o,
    output logic                  memToReg_o,
    output logic                  memRead_o,
    output logic                  memWrite_o,
    output logic                  aluSrc_o,
    output logic                  regDst_o,
    output logic [ALUOP_W-1:0]    aluOp_o,
    output logic                  valid_o,
    output logic                  hazard_o,
    output logic [BCNT_W-1:0]     bubbleCount_o
);

    ctrl_t             r_ctrl;
    opnd_t             r_opnd;
    logic              r_valid;
    logic [BCNT_W-1:0] r_bcnt;

    ctrl_t w_ctrl_in;
    opnd_t w_opnd_in;
    logic  w_hazard;
    logic  w_bubble;

    assign w_ctrl_in = '{reg_write:  regWrite_i,
                         mem_to_reg: memToReg_i,
                         mem_read:   memRead_i,
                         mem_write:  memWrite_i,
                         alu_src:    aluSrc_i,
                         reg_dst:    regDst_i,
                         alu_op:     aluOp_i};

    assign w_opnd_in = '{rs_data: rsData_i,
                         rt_data: rtData_i,
                         imm:     imm_i,
                         rs_addr: rsAddr_i,
                         rt_addr: rtAddr_i,
                         rd_addr: rdAddr_i};

    hazard_detect u_hazard_detect (
        .i_stall       (stall_i),
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rt_addr  (r_opnd.rt_addr),
        .i_id_rs_addr  (rsAddr_i),
        .i_id_rt_addr  (rtAddr_i),
        .o_hazard_c    (w_hazard)
    );

    // w_hazard is already gated by stall, but the stall branch below takes priority anyway.
    assign w_bubble = flush_i | w_hazard;

    // Pipeline register and bubble counter: reset > stall > bubble > load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl  <= CTRL_ZERO;
            r_opnd  <= '0;
            r_valid <= 1'b0;
            r_bcnt  <= '0;
        end else if (!stall_i) begin
            r_opnd <= w_opnd_in;
            if (w_bubble) begin
                r_ctrl  <= bubble_ctrl(w_ctrl_in);
                r_valid <= 1'b0;
                if (r_bcnt != {BCNT_W{1'b1}}) begin
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
            end else begin
                r_ctrl  <= w_ctrl_in;
                r_valid <= 1'b1;
            end
        end
    end

    assign rsData_o      = r_opnd.rs_data;
    assign rtData_o      = r_opnd.rt_data;
    assign imm_o         = r_opnd.imm;
    assign rsAddr_o      = r_opnd.rs_addr;
    assign rtAddr_o      = r_opnd.rt_addr;
    assign rdAddr_o      = r_opnd.rd_addr;
    assign regWrite_o    = r_ctrl.reg_write;
    assign memToReg_o    = r_ctrl.mem_to_reg;
    assign memRead_o     = r_ctrl.mem_read;
    assign memWrite_o    = r_ctrl.mem_write;
    assign aluSrc_o      = r_ctrl.alu_src;
    assign regDst_o      = r_ctrl.reg_dst;
    assign aluOp_o       = r_ctrl.alu_op;
    assign valid_o       = r_valid;
    assign hazard_o      = w_hazard;
    assign bubbleCount_o = r_bcnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: default-width DUT plus a 2-bit-counter DUT for saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, flush_i;
    logic [31:0] rsData_i, rtData_i, imm_i;
    logic [4:0]  rsAddr_i, rtAddr_i, rdAddr_i;
    logic        regWrite_i, memToReg_i, memRead_i, memWrite_i, aluSrc_i, regDst_i;
    logic [1:0]  aluOp_i;

    logic [31:0] rsData_o, rtData_o, imm_o;
    logic [4:0]  rsAddr_o, rtAddr_o, rdAddr_o;
    logic        regWrite_o, memToReg_o, memRead_o, memWrite_o, aluSrc_o, regDst_o;
    logic [1:0]  aluOp_o;
    logic        valid_o, hazard_o;
    logic [15:0] bubbleCount_o;

    logic [31:0] s_rsData, s_rtData, s_imm;
    logic [4:0]  s_rsAddr, s_rtAddr, s_rdAddr;
    logic        s_regWrite, s_memToReg, s_memRead, s_memWrite, s_aluSrc, s_regDst;
    logic [1:0]  s_aluOp;
    logic        s_valid, s_hazard;
    logic [1:0]  s_bcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage u_dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .rsData_i(rsData_i), .rtData_i(rtData_i), .imm_i(imm_i),
        .rsAddr_i(rsAddr_i), .rtAddr_i(rtAddr_i), .rdAddr_i(rdAddr_i),
        .regWrite_i(regWrite_i), .memToReg_i(memToReg_i), .memRead_i(memRead_i),
        .memWrite_i(memWrite_i), .aluSrc_i(aluSrc_i), .regDst_i(regDst_i), .aluOp_i(aluOp_i),
        .rsData_o(rsData_o), .rtData_o(rtData_o), .imm_o(imm_o),
        .rsAddr_o(rsAddr_o), .rtAddr_o(rtAddr_o), .rdAddr_o(rdAddr_o),
        .regWrite_o(regWrite_o), .memToReg_o(memToReg_o), .memRead_o(memRead_o),
        .memWrite_o(memWrite_o), .aluSrc_o(aluSrc_o), .regDst_o(regDst_o), .aluOp_o(aluOp_o),
        .valid_o(valid_o), .hazard_o(hazard_o), .bubbleCount_o(bubbleCount_o)
    );

    id_ex_stage #(.BCNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .rsData_i(rsData_i), .rtData_i(rtData_i), .imm_i(imm_i),
        .rsAddr_i(rsAddr_i), .rtAddr_i(rtAddr_i), .rdAddr_i(rdAddr_i),
        .regWrite_i(regWrite_i), .memToReg_i(memToReg_i), .memRead_i(memRead_i),
        .memWrite_i(memWrite_i), .aluSrc_i(aluSrc_i), .regDst_i(regDst_i), .aluOp_i(aluOp_i),
        .rsData_o(s_rsData), .rtData_o(s_rtData), .imm_o(s_imm),
        .rsAddr_o(s_rsAddr), .rtAddr_o(s_rtAddr), .rdAddr_o(s_rdAddr),
        .regWrite_o(s_regWrite), .memToReg_o(s_memToReg), .memRead_o(s_memRead),
        .memWrite_o(s_memWrite), .aluSrc_o(s_aluSrc), .regDst_o(s_regDst), .aluOp_o(s_aluOp),
        .valid_o(s_valid), .hazard_o(s_hazard), .bubbleCount_o(s_bcnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [5:0] ctl, input logic [1:0] op);
        rsData_i = rsd; rtData_i = rtd; imm_i = im;
        rsAddr_i = rs; rtAddr_i = rt; rdAddr_i = rd;
        {regWrite_i, memToReg_i, memRead_i, memWrite_i, aluSrc_i, regDst_i} = ctl;
        aluOp_i = op;
    endtask

    initial begin
        // Reset with every other input active to prove reset dominates.
        rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
        set_instr(32'hDEADBEEF, 32'hCAFEF00D, 32'h1, 5'd3, 5'd4, 5'd6, 6'b111111, 2'b11);
        #2;
        tick();
        chk("rst_rsData", 64'(rsData_o), 64'h0);
        chk("rst_rtData", 64'(rtData_o), 64'h0);
        chk("rst_rtAddr", 64'(rtAddr_o), 64'h0);
        chk("rst_ctrl", 64'({regWrite_o, memToReg_o, memRead_o, memWrite_o, aluSrc_o, regDst_o, aluOp_o}), 64'h0);
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_bcnt", 64'(bubbleCount_o), 64'h0);
        chk("rst_hazard", 64'(hazard_o), 64'h0);

        // Plain load: one-cycle latency.
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        set_instr(32'h12345678, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0, 6'b100000, 2'b00);
        tick();
        chk("ld_rsData", 64'(rsData_o), 64'h12345678);
        chk("ld_rtAddr", 64'(rtAddr_o), 64'd5);
        chk("ld_regWrite", 64'(regWrite_o), 64'h1);
        chk("ld_valid", 64'(valid_o), 64'h1);
        chk("ld_hazard", 64'(hazard_o), 64'h0);

        // lw r5 into EX, then dependent rs=5 in ID.
        set_instr(32'h0, 32'h0, 32'h10, 5'd2, 5'd5, 5'd7, 6'b111010, 2'b00);
        tick();
        chk("lw_memRead", 64'(memRead_o), 64'h1);
        chk("lw_imm", 64'(imm_o), 64'h10);
        set_instr(32'hAAAA0001, 32'hBBBB0002, 32'h0, 5'd5, 5'd6, 5'd8, 6'b100001, 2'b10);
        #1;
        chk("lu_hazard_now", 64'(hazard_o), 64'h1);
        tick();
        chk("lu_valid", 64'(valid_o), 64'h0);
        chk("lu_memRead", 64'(memRead_o), 64'h0);
        chk("lu_regWrite", 64'(regWrite_o), 64'h0);
        chk("lu_aluOp_dc", 64'(aluOp_o), 64'h2);
        chk("lu_rsData_dc", 64'(rsData_o), 64'hAAAA0001);
        chk("lu_bcnt", 64'(bubbleCount_o), 64'd1);
        chk("lu_hazard_next", 64'(hazard_o), 64'h0);
        tick();
        chk("lu_reload_valid", 64'(valid_o), 64'h1);
        chk("lu_reload_regWrite", 64'(regWrite_o), 64'h1);
        chk("lu_reload_bcnt", 64'(bubbleCount_o), 64'd1);

        // lw targeting r0: never a hazard.
        set_instr(32'h0, 32'h0, 32'h4, 5'd2, 5'd0, 5'd0, 6'b111010, 2'b00);
        tick();
        set_instr(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, 6'b100001, 2'b10);
        #1;
        chk("r0_hazard", 64'(hazard_o), 64'h0);
        tick();
        chk("r0_valid", 64'(valid_o), 64'h1);
        chk("r0_bcnt", 64'(bubbleCount_o), 64'd1);

        // rt match with simultaneous flush: a single bubble.
        set_instr(32'h0, 32'h0, 32'h8, 5'd2, 5'd9, 5'd0, 6'b111010, 2'b00);
        tick();
        set_instr(32'h0, 32'h0, 32'h0, 5'd3, 5'd9, 5'd10, 6'b100001, 2'b10);
        flush_i = 1'b1;
        #1;
        chk("rt_hazard", 64'(hazard_o), 64'h1);
        tick();
        flush_i = 1'b0;
        chk("both_valid", 64'(valid_o), 64'h0);
        chk("both_bcnt", 64'(bubbleCount_o), 64'd2);

        // Stall for 3 cycles with flush and a pending load-use; everything holds.
        set_instr(32'h00000055, 32'h0, 32'h0, 5'd2, 5'd4, 5'd0, 6'b111010, 2'b00);
        tick();
        stall_i = 1'b1; flush_i = 1'b1;
        set_instr(32'h00000099, 32'h0, 32'h0, 5'd4, 5'd1, 5'd11, 6'b100001, 2'b01);
        #1;
        chk("stall_hazard", 64'(hazard_o), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rsData", 64'(rsData_o), 64'h55);
            chk("stall_valid", 64'(valid_o), 64'h1);
            chk("stall_bcnt", 64'(bubbleCount_o), 64'd2);
        end
        stall_i = 1'b0;
        tick();
        flush_i = 1'b0;
        chk("unstall_valid", 64'(valid_o), 64'h0);
        chk("unstall_rsData", 64'(rsData_o), 64'h99);
        chk("unstall_bcnt", 64'(bubbleCount_o), 64'd3);
        chk("unstall_sat_bcnt", 64'(s_bcnt), 64'd3);

        // Reset in the middle of a stall discards the held instruction.
        set_instr(32'h0000F00D, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000, 2'b00);
        tick();
        stall_i = 1'b1; rst_i = 1'b1;
        tick();
        chk("rst_stall_valid", 64'(valid_o), 64'h0);
        chk("rst_stall_rsData", 64'(rsData_o), 64'h0);
        chk("rst_stall_bcnt", 64'(bubbleCount_o), 64'h0);
        chk("rst_stall_sat_bcnt", 64'(s_bcnt), 64'h0);
        rst_i = 1'b0; stall_i = 1'b0;
        set_instr(32'h0000BEEF, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000, 2'b00);
        tick();
        chk("post_rst_valid", 64'(valid_o), 64'h1);
        chk("post_rst_rsData", 64'(rsData_o), 64'hBEEF);

        // Five bubbles: 2-bit counter saturates at 3, 16-bit keeps counting.
        flush_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat_bcnt2", 64'(s_bcnt), 64'((i > 3) ? 3 : i));
            chk("sat_bcnt16", 64'(bubbleCount_o), 64'(i));
        end
        flush_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
